// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module      : memarb_pkg
// Description : Shared state encoding and default constants for mem_arbiter.
//               Optional feature macro: MEMARB_ROM_PROTECT_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package memarb_pkg;

    typedef enum logic [1:0] {
        CPU   = 2'd0,
        DSLOT = 2'd1,
        DRET  = 2'd2
    } memarb_state_t;

    localparam int          CPU_SLOTS_DEFAULT = 1;
    localparam logic [15:0] ROM_TOP_DEFAULT   = 16'h4000;
    localparam int          GAP_W             = 4;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : CPU, DMA and memory buses of the arbiter. The violation flag
//               exists only when MEMARB_ROM_PROTECT_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if;

    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_wren;
    logic [7:0]  cpu_idata;
    logic        cpu_ce;

    logic        dma_req;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_wren;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic        dma_valid;

    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wren;
    logic [7:0]  mem_rdata;

`ifdef MEMARB_ROM_PROTECT_EN
    logic        violation;
`endif

    // Arbiter side.
    modport slave (
        input  cpu_addr, cpu_wdata, cpu_wren,
        output cpu_idata, cpu_ce,
        input  dma_req, dma_addr, dma_wdata, dma_wren,
        output dma_ack, dma_rdata, dma_valid,
        output mem_addr, mem_wdata, mem_wren,
        input  mem_rdata
`ifdef MEMARB_ROM_PROTECT_EN
        , output violation
`endif
    );

    // Requester / memory side.
    modport master (
        output cpu_addr, cpu_wdata, cpu_wren,
        input  cpu_idata, cpu_ce,
        output dma_req, dma_addr, dma_wdata, dma_wren,
        input  dma_ack, dma_rdata, dma_valid,
        input  mem_addr, mem_wdata, mem_wren,
        output mem_rdata
`ifdef MEMARB_ROM_PROTECT_EN
        , input violation
`endif
    );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Single-port memory arbiter that steals one stall cycle from
//               the CPU per DMA slot. Optional MEMARB_ROM_PROTECT_EN blocks
//               writes below ROM_TOP and raises a sticky violation flag.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import memarb_pkg::*;
#(
    parameter int          CPU_SLOTS = CPU_SLOTS_DEFAULT,
    parameter logic [15:0] ROM_TOP   = ROM_TOP_DEFAULT
) (
    input  wire logic      clock,
    input  wire logic      reset,
    mem_arbiter_if.slave   bus
);

    localparam logic [GAP_W-1:0] SLOTS = GAP_W'(CPU_SLOTS);

    // A zero ROM_TOP would protect nothing, so it is rejected alongside the slot range.
    if (CPU_SLOTS < 1 || CPU_SLOTS > 15 || ROM_TOP == 16'h0000) begin : g_param_check
        $error("mem_arbiter: CPU_SLOTS must be 1..15 and ROM_TOP non-zero");
    end

    memarb_state_t    state;
    logic [GAP_W-1:0] gap;
    logic [7:0]       hold;
    logic             slot_is_read;
    logic [7:0]       dma_rdata_q;

    logic             in_slot;
    logic             wr_req;
    logic             blocked;

    assign in_slot = (state == DSLOT);
    assign wr_req  = in_slot ? bus.dma_wren : bus.cpu_wren;

    assign bus.mem_addr  = in_slot ? bus.dma_addr  : bus.cpu_addr;
    assign bus.mem_wdata = in_slot ? bus.dma_wdata : bus.cpu_wdata;

`ifdef MEMARB_ROM_PROTECT_EN
    assign blocked = wr_req && (bus.mem_addr < ROM_TOP);
`else
    assign blocked = 1'b0;
`endif

    assign bus.mem_wren  = ~reset & wr_req & ~blocked;
    assign bus.cpu_ce    = ~reset & ~in_slot;
    assign bus.cpu_idata = (state == DRET) ? hold : bus.mem_rdata;
    assign bus.dma_ack   = in_slot;
    assign bus.dma_valid = (state == DRET) && slot_is_read;
    assign bus.dma_rdata = bus.dma_valid ? bus.mem_rdata : dma_rdata_q;

    // DRET is CPU-owned, so the gap counter advances there as well as in CPU.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= CPU;
            gap          <= SLOTS;
            hold         <= 8'h00;
            slot_is_read <= 1'b0;
            dma_rdata_q  <= 8'h00;
        end else begin
            case (state)
                CPU: begin
                    if (bus.dma_req && (gap >= SLOTS)) begin
                        state <= DSLOT;
                        gap   <= '0;
                    end else if (gap < SLOTS) begin
                        gap <= gap + 1'b1;
                    end
                end
                DSLOT: begin
                    state        <= DRET;
                    hold         <= bus.mem_rdata;
                    slot_is_read <= ~bus.dma_wren;
                end
                DRET: begin
                    state <= CPU;
                    if (gap < SLOTS) begin
                        gap <= gap + 1'b1;
                    end
                    if (slot_is_read) begin
                        dma_rdata_q <= bus.mem_rdata;
                    end
                end
                default: state <= CPU;
            endcase
        end
    end

`ifdef MEMARB_ROM_PROTECT_EN
    logic violation_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            violation_q <= 1'b0;
        end else if (blocked) begin
            violation_q <= 1'b1;
        end
    end

    assign bus.violation = violation_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a transaction-level
//               reference model. Honours MEMARB_ROM_PROTECT_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int          SLOTS     = 2;
    localparam logic [15:0] ROM_LIMIT = 16'h4000;
    localparam int          K_CPU     = 0;
    localparam int          K_SLOT    = 1;
    localparam int          K_RET     = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mem_arbiter_if bus ();

    mem_arbiter #(.CPU_SLOTS(SLOTS), .ROM_TOP(ROM_LIMIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Memory device: one-cycle read latency, read returns the pre-write value.
    bit [7:0] ram [0:65535];
    always @(posedge clock) begin
        if (reset) begin
            ram[16'h0100] <= 8'hA5;
            ram[16'h2000] <= 8'h3C;
        end else if (bus.mem_wren) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    int checks   = 0;
    int failures = 0;

    // Reference model: cycle kind, time of last slot, expected read data.
    bit [7:0] ref_mem [0:65535];
    int       cyc      = 0;
    int       kind     = K_CPU;
    int       last_ack = -1000;
    bit       m_slot_rd, m_have, m_viol;
    bit [7:0] m_cpu_exp, m_dma_exp;

    logic        s_ce, s_ack, s_valid, s_wren, s_viol;
    logic [7:0]  s_rdata, s_idata, s_wdata;
    logic [15:0] s_addr;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit rom_blocked(input bit wr, input logic [15:0] addr);
`ifdef MEMARB_ROM_PROTECT_EN
        return wr && (addr < ROM_LIMIT);
`else
        return 1'b0 & wr & addr[0];
`endif
    endfunction

    task automatic compare();
        bit          in_slot, wr, exp_valid, exp_wren;
        logic [15:0] exp_addr;
        s_ce = bus.cpu_ce;   s_ack = bus.dma_ack;     s_valid = bus.dma_valid;
        s_wren = bus.mem_wren; s_rdata = bus.dma_rdata; s_idata = bus.cpu_idata;
        s_addr = bus.mem_addr; s_wdata = bus.mem_wdata;
`ifdef MEMARB_ROM_PROTECT_EN
        s_viol = bus.violation;
`else
        s_viol = 1'b0;
`endif
        if (reset) begin
            chk("rst_cpu_ce", bus.cpu_ce, 1'b0);
            chk("rst_dma_ack", bus.dma_ack, 1'b0);
            chk("rst_dma_valid", bus.dma_valid, 1'b0);
            chk("rst_mem_wren", bus.mem_wren, 1'b0);
            chk("rst_dma_rdata", bus.dma_rdata, 8'h00);
`ifdef MEMARB_ROM_PROTECT_EN
            chk("rst_violation", bus.violation, 1'b0);
`endif
        end else begin
            in_slot   = (kind == K_SLOT);
            exp_valid = (kind == K_RET) && m_slot_rd;
            chk("cpu_ce", bus.cpu_ce, !in_slot);
            chk("dma_ack", bus.dma_ack, in_slot);
            chk("dma_valid", bus.dma_valid, exp_valid);
            if (exp_valid) chk("dma_rdata", bus.dma_rdata, m_dma_exp);
            if (!in_slot && m_have) chk("cpu_idata", bus.cpu_idata, m_cpu_exp);
            exp_addr = in_slot ? bus.dma_addr : bus.cpu_addr;
            wr       = in_slot ? bus.dma_wren : bus.cpu_wren;
            exp_wren = wr && !rom_blocked(wr, exp_addr);
            chk("mem_addr", bus.mem_addr, exp_addr);
            chk("mem_wren", bus.mem_wren, exp_wren);
            if (exp_wren) chk("mem_wdata", bus.mem_wdata, in_slot ? bus.dma_wdata : bus.cpu_wdata);
`ifdef MEMARB_ROM_PROTECT_EN
            chk("violation", bus.violation, m_viol);
`endif
        end
    endtask

    task automatic model_step();
        bit          grant, wr, blk;
        logic [15:0] addr;
        if (reset) begin
            kind = K_CPU; last_ack = -1000; m_slot_rd = 0; m_have = 0; m_viol = 0;
            ref_mem[16'h0100] = 8'hA5;
            ref_mem[16'h2000] = 8'h3C;
        end else begin
            wr   = (kind == K_SLOT) ? bus.dma_wren : bus.cpu_wren;
            addr = (kind == K_SLOT) ? bus.dma_addr : bus.cpu_addr;
            blk  = rom_blocked(wr, addr);
            if (kind != K_SLOT) begin
                m_cpu_exp = ref_mem[bus.cpu_addr];
                m_have    = 1;
                if (bus.cpu_wren && !blk) ref_mem[bus.cpu_addr] = bus.cpu_wdata;
            end else begin
                last_ack  = cyc;
                m_slot_rd = !bus.dma_wren;
                if (bus.dma_wren) begin
                    if (!blk) ref_mem[bus.dma_addr] = bus.dma_wdata;
                end else begin
                    m_dma_exp = ref_mem[bus.dma_addr];
                end
            end
            if (blk) m_viol = 1;
            grant = (kind == K_CPU) && bus.dma_req && (cyc - last_ack >= SLOTS + 1);
            kind  = grant ? K_SLOT : ((kind == K_SLOT) ? K_RET : K_CPU);
        end
        cyc++;
    endtask

    // Compare the cycle just driven, then advance the model at the edge.
    task automatic tick();
        @(negedge clock);
        compare();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic set_cpu(input logic [15:0] a, input logic w, input logic [7:0] d);
        bus.cpu_addr = a; bus.cpu_wren = w; bus.cpu_wdata = d;
    endtask

    task automatic set_dma(input logic r, input logic [15:0] a, input logic w, input logic [7:0] d);
        bus.dma_req = r; bus.dma_addr = a; bus.dma_wren = w; bus.dma_wdata = d;
    endtask

    initial begin
        int nacks, nlow, nvalid, prev_ack, cpu_i;
        reset = 1'b1;
        set_cpu(16'h0000, 1'b0, 8'h00);
        set_dma(1'b0, 16'h0000, 1'b0, 8'h00);
        repeat (3) tick();
        chk("reset_ce_literal", s_ce, 1'b0);

        // CPU alone reading 0x0100.
        reset = 1'b0;
        set_cpu(16'h0100, 1'b0, 8'h00);
        tick();
        chk("release_ce", s_ce, 1'b1);
        tick();
        chk("cpu_read_a5", s_idata, 8'hA5);
        repeat (3) tick();

        // Single DMA read; request dropped in the slot-entry cycle.
        set_dma(1'b1, 16'h2000, 1'b0, 8'h00);
        tick();
        chk("grant_cycle_ack", s_ack, 1'b0);
        bus.dma_req = 1'b0;
        tick();
        chk("slot_ack", s_ack, 1'b1);
        chk("slot_ce", s_ce, 1'b0);
        tick();
        chk("ret_valid", s_valid, 1'b1);
        chk("ret_dma_rdata", s_rdata, 8'h3C);
        chk("ret_cpu_idata", s_idata, 8'hA5);
        tick();
        chk("post_valid", s_valid, 1'b0);

        // CPU fills a small table.
        for (int i = 0; i < 6; i++) begin
            set_cpu(16'h8100 + 16'(i), 1'b1, 8'(i * 3 + 1));
            tick();
        end

        // Continuous DMA reads while the CPU sweeps the table.
        set_cpu(16'h8100, 1'b0, 8'h00);
        set_dma(1'b1, 16'h8100, 1'b0, 8'h00);
        nacks = 0; nlow = 0; prev_ack = -1; cpu_i = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (s_ack === 1'b1) begin
                if (prev_ack >= 0) chk("ack_period", 16'(c - prev_ack), 16'd4);
                prev_ack = c;
                nacks++;
                bus.dma_addr = bus.dma_addr + 16'd1;
            end
            if (s_ce !== 1'b1) nlow++;
            if (s_ce === 1'b1) begin
                cpu_i = (cpu_i + 1) % 6;
                bus.cpu_addr = 16'h8100 + 16'(cpu_i);
            end
        end
        chk("ack_count", 16'(nacks), 16'd4);
        chk("ce_low_count", 16'(nlow), 16'd4);
        bus.dma_req = 1'b0;
        repeat (4) tick();

        // Coincident CPU and DMA writes; CPU write held through the slot.
        set_cpu(16'h8000, 1'b1, 8'h77);
        set_dma(1'b1, 16'h8001, 1'b1, 8'h11);
        tick();
        bus.dma_req = 1'b0;
        tick();
        chk("slot_wr_addr", s_addr, 16'h8001);
        chk("slot_wr_en", s_wren, 1'b1);
        chk("slot_wr_data", s_wdata, 8'h11);
        tick();
        chk("ret_wr_addr", s_addr, 16'h8000);
        chk("ret_wr_en", s_wren, 1'b1);
        chk("ret_wr_data", s_wdata, 8'h77);
        set_cpu(16'h8000, 1'b0, 8'h00);
        set_dma(1'b0, 16'h0000, 1'b0, 8'h00);
        tick();
        tick();
        chk("ram_8000", ram[16'h8000], 8'h77);
        chk("ram_8001", ram[16'h8001], 8'h11);
        repeat (3) tick();

        // Reset lands in the DMA slot.
        set_dma(1'b1, 16'h2000, 1'b0, 8'h00);
        tick();
        bus.dma_req = 1'b0;
        reset = 1'b1;
        tick();
        chk("abort_ack", s_ack, 1'b0);
        tick();
        reset = 1'b0;
        nvalid = 0;
        tick();
        chk("abort_release_ce", s_ce, 1'b1);
        chk("abort_release_wren", s_wren, 1'b0);
        if (s_valid === 1'b1) nvalid++;
        repeat (4) begin
            tick();
            if (s_valid === 1'b1) nvalid++;
        end
        chk("abort_no_valid", 16'(nvalid), 16'd0);

`ifdef MEMARB_ROM_PROTECT_EN
        // DMA write into the protected region.
        set_dma(1'b1, 16'h0010, 1'b1, 8'hEE);
        tick();
        bus.dma_req = 1'b0;
        tick();
        chk("rom_ack", s_ack, 1'b1);
        chk("rom_wren", s_wren, 1'b0);
        set_dma(1'b0, 16'h0000, 1'b0, 8'h00);
        repeat (3) begin
            tick();
            chk("rom_violation_sticky", s_viol, 1'b1);
        end
        reset = 1'b1;
        tick();
        chk("rom_violation_rst", s_viol, 1'b0);
        reset = 1'b0;
        tick();
        chk("rom_violation_after", s_viol, 1'b0);
        chk("rom_ram_untouched", ram[16'h0010], 8'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
